// File: rtl/register_bank_mp_if.sv
// Bus bundle for register_bank_mp: write ports, read ports, scoreboard alloc and status.
// The bank drives the slave side; the pipeline (or a bench) drives the master side.
interface register_bank_mp_if #(
    parameter int REGISTER_SIZE = 32,
    parameter int ADDRESS_SIZE  = 5,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 2
);
    logic [WRITE_PORTS-1:0]               write;
    logic [WRITE_PORTS*ADDRESS_SIZE-1:0]  addr_in;
    logic [WRITE_PORTS*REGISTER_SIZE-1:0] data_in;
    logic [READ_PORTS*ADDRESS_SIZE-1:0]   addr_out;
    logic [READ_PORTS*REGISTER_SIZE-1:0]  data_out;
    logic [READ_PORTS-1:0]                busy_out;
    logic                                 alloc;
    logic [ADDRESS_SIZE-1:0]              alloc_addr;
    logic [ADDRESS_SIZE:0]                busy_count;

    modport master (
        output write, addr_in, data_in, addr_out, alloc, alloc_addr,
        input  data_out, busy_out, busy_count
    );

    modport slave (
        input  write, addr_in, data_in, addr_out, alloc, alloc_addr,
        output data_out, busy_out, busy_count
    );
endinterface

// File: rtl/register_bank_mp.sv
// Multi-port register bank with per-register busy scoreboard; register 0 reads as zero.
// Optional write-through read forwarding when REGISTER_BANK_MP_BYPASS_EN is defined.
module register_bank_mp #(
    parameter int REGISTER_SIZE = 32,
    parameter int ADDRESS_SIZE  = 5,
    parameter int READ_PORTS    = 2,
    parameter int WRITE_PORTS   = 2
) (
    input  logic              clk,
    input  logic              reset,
    register_bank_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDRESS_SIZE;

    logic [REGISTER_SIZE-1:0] regs_q [DEPTH];
    logic [REGISTER_SIZE-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [ADDRESS_SIZE:0]    busy_count_q, busy_count_d;

    logic [ADDRESS_SIZE-1:0]             wr_addr;
    logic [ADDRESS_SIZE-1:0]             rd_addr;
    logic [READ_PORTS*REGISTER_SIZE-1:0] data_out_c;
    logic [READ_PORTS-1:0]               busy_out_c;
`ifdef REGISTER_BANK_MP_BYPASS_EN
    logic [ADDRESS_SIZE-1:0]             fwd_addr;
`endif

    // Ascending port order lets the highest-index writer win; alloc is applied last so it beats a clear.
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        wr_addr = '0;
        for (int k = 0; k < WRITE_PORTS; k++) begin
            wr_addr = bus.addr_in[k*ADDRESS_SIZE +: ADDRESS_SIZE];
            if (bus.write[k] && (wr_addr != '0)) begin
                regs_d[wr_addr] = bus.data_in[k*REGISTER_SIZE +: REGISTER_SIZE];
                busy_d[wr_addr] = 1'b0;
            end
        end
        if (bus.alloc && (bus.alloc_addr != '0)) begin
            busy_d[bus.alloc_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;

        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + {{ADDRESS_SIZE{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_comb begin
        data_out_c = '0;
        busy_out_c = '0;
        rd_addr    = '0;
`ifdef REGISTER_BANK_MP_BYPASS_EN
        fwd_addr   = '0;
`endif
        for (int j = 0; j < READ_PORTS; j++) begin
            rd_addr = bus.addr_out[j*ADDRESS_SIZE +: ADDRESS_SIZE];
            data_out_c[j*REGISTER_SIZE +: REGISTER_SIZE] = regs_q[rd_addr];
            busy_out_c[j] = busy_q[rd_addr];
`ifdef REGISTER_BANK_MP_BYPASS_EN
            for (int k = 0; k < WRITE_PORTS; k++) begin
                fwd_addr = bus.addr_in[k*ADDRESS_SIZE +: ADDRESS_SIZE];
                if (bus.write[k] && (fwd_addr == rd_addr) && (rd_addr != '0)) begin
                    data_out_c[j*REGISTER_SIZE +: REGISTER_SIZE] =
                        bus.data_in[k*REGISTER_SIZE +: REGISTER_SIZE];
                    busy_out_c[j] = bus.alloc && (bus.alloc_addr == rd_addr);
                end
            end
`endif
        end
    end

    assign bus.data_out   = data_out_c;
    assign bus.busy_out   = busy_out_c;
    assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed self-checking bench for register_bank_mp (default 32x32, 2 read / 2 write ports).
// Expected values adapt to whether REGISTER_BANK_MP_BYPASS_EN is defined.
module tb_register_bank_mp;
    localparam int RS = 32;
    localparam int AS = 5;
    localparam int RP = 2;
    localparam int WP = 2;

`ifdef REGISTER_BANK_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    register_bank_mp_if #(.REGISTER_SIZE(RS), .ADDRESS_SIZE(AS),
                          .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

    register_bank_mp #(.REGISTER_SIZE(RS), .ADDRESS_SIZE(AS),
                       .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(input int j);
        return bus.data_out[j*RS +: RS];
    endfunction

    function automatic logic [31:0] bz(input int j);
        return {31'd0, bus.busy_out[j]};
    endfunction

    function automatic logic [31:0] cnt();
        return {26'd0, bus.busy_count};
    endfunction

    task automatic idle();
        bus.write      = '0;
        bus.addr_in    = '0;
        bus.data_in    = '0;
        bus.alloc      = 1'b0;
        bus.alloc_addr = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        bus.addr_out = '0;

        // Reset with writes and alloc active: all must be ignored
        reset          = 1'b0;
        bus.write      = 2'b11;
        bus.addr_in    = {5'd4, 5'd3};
        bus.data_in    = {32'hAAAA_AAAA, 32'hBBBB_BBBB};
        bus.alloc      = 1'b1;
        bus.alloc_addr = 5'd6;
        tick();
        tick();
        reset = 1'b1;
        idle();
        bus.addr_out = {5'd4, 5'd3};
        #1;
        chk("rst_reg3", rd(0), 32'h0);
        chk("rst_reg4", rd(1), 32'h0);
        chk("rst_count", cnt(), 32'd0);
        bus.addr_out = {5'd3, 5'd6};
        #1;
        chk("rst_busy6", bz(0), 32'd0);

        // Single write to reg 5, latency check
        bus.write    = 2'b01;
        bus.addr_in  = {5'd0, 5'd5};
        bus.data_in  = {32'h0, 32'hDEAD_BEEF};
        bus.addr_out = {5'd0, 5'd5};
        #1;
        chk("wr5_same_cycle", rd(0), BYP ? 32'hDEAD_BEEF : 32'h0);
        tick();
        idle();
        #1;
        chk("wr5_next_cycle", rd(0), 32'hDEAD_BEEF);
        chk("wr5_not_busy", bz(0), 32'd0);

        // Write conflict on reg 7: port 1 wins
        bus.write    = 2'b11;
        bus.addr_in  = {5'd7, 5'd7};
        bus.data_in  = {32'h22, 32'h11};
        bus.addr_out = {5'd7, 5'd5};
        #1;
        chk("conflict_same_cycle", rd(1), BYP ? 32'h22 : 32'h0);
        tick();
        bus.write    = 2'b10;
        bus.addr_in  = {5'd0, 5'd0};
        bus.data_in  = {32'hFF, 32'h0};
        bus.addr_out = {5'd0, 5'd7};
        #1;
        chk("conflict_reg7", rd(0), 32'h22);
        chk("reg0_write_cycle", rd(1), 32'h0);
        tick();
        idle();
        #1;
        chk("reg0_after_write", rd(1), 32'h0);
        chk("reg7_hold", rd(0), 32'h22);

        // Alloc 9 then writeback clears it
        bus.alloc      = 1'b1;
        bus.alloc_addr = 5'd9;
        bus.addr_out   = {5'd0, 5'd9};
        #1;
        chk("alloc9_not_yet", bz(0), 32'd0);
        tick();
        idle();
        #1;
        chk("alloc9_busy", bz(0), 32'd1);
        chk("alloc9_count", cnt(), 32'd1);
        bus.write   = 2'b01;
        bus.addr_in = {5'd0, 5'd9};
        bus.data_in = {32'h0, 32'h99};
        #1;
        chk("wb9_same_cycle_busy", bz(0), BYP ? 32'd0 : 32'd1);
        tick();
        idle();
        #1;
        chk("wb9_busy_clear", bz(0), 32'd0);
        chk("wb9_count", cnt(), 32'd0);
        chk("wb9_data", rd(0), 32'h99);

        // Alloc and write same reg while already busy: busy wins
        bus.alloc      = 1'b1;
        bus.alloc_addr = 5'd9;
        tick();
        chk("realloc9_count", cnt(), 32'd1);
        bus.write   = 2'b10;
        bus.addr_in = {5'd9, 5'd0};
        bus.data_in = {32'h1234, 32'h0};
        #1;
        chk("alloc_wr9_same_busy", bz(0), 32'd1);
        chk("alloc_wr9_same_data", rd(0), BYP ? 32'h1234 : 32'h99);
        tick();
        idle();
        #1;
        chk("alloc_wr9_busy", bz(0), 32'd1);
        chk("alloc_wr9_count", cnt(), 32'd1);
        chk("alloc_wr9_data", rd(0), 32'h1234);

        // Fill the scoreboard 1..31 (9 already busy)
        for (int i = 1; i < 32; i++) begin
            bus.alloc      = 1'b1;
            bus.alloc_addr = 5'(i);
            tick();
        end
        chk("fill_count", cnt(), 32'd31);
        bus.alloc_addr = 5'd0;
        bus.addr_out   = {5'd0, 5'd31};
        tick();
        chk("alloc0_count", cnt(), 32'd31);
        chk("alloc0_busy", bz(1), 32'd0);
        chk("busy31", bz(0), 32'd1);

        // Reset in the middle of allocs
        bus.alloc_addr = 5'd3;
        reset          = 1'b0;
        tick();
        reset = 1'b1;
        idle();
        bus.addr_out = {5'd5, 5'd9};
        #1;
        chk("midrst_count", cnt(), 32'd0);
        chk("midrst_busy9", bz(0), 32'd0);
        chk("midrst_reg5", rd(1), 32'h0);
        tick();
        chk("midrst_count_hold", cnt(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/register_bank_mp.md
Name: register_bank_mp

Overview:
Parametrised multi-port successor to the single-write register bank, for the superscalar pipeline.
- Provides READ_PORTS combinational read ports and WRITE_PORTS synchronous write ports, all on one rising-edge clock.
- Register 0 is hardwired to zero.
- A per-register busy scoreboard is set at issue (alloc) and cleared at writeback; decode uses it to detect pending producers.

Parameters:
REGISTER_SIZE, 32, data width of each register
ADDRESS_SIZE, 5, address width; depth = 1<<ADDRESS_SIZE
READ_PORTS, 2, number of independent read ports (>=1)
WRITE_PORTS, 2, number of write ports (>=1); higher index has priority

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset
write  input  WRITE_PORTS  per-port write enable
addr_in  input  WRITE_PORTS*ADDRESS_SIZE  write addresses, port k at bits [k*ADDRESS_SIZE +: ADDRESS_SIZE]
data_in  input  WRITE_PORTS*REGISTER_SIZE  write data, port k sliced likewise
addr_out  input  READ_PORTS*ADDRESS_SIZE  read addresses, port j sliced likewise
data_out  output  READ_PORTS*REGISTER_SIZE  read data, port j sliced likewise
busy_out  output  READ_PORTS  scoreboard bit of addr_out[j]
alloc  input  1  reserve destination: set busy for alloc_addr
alloc_addr  input  ADDRESS_SIZE  register being reserved
busy_count  output  ADDRESS_SIZE+1  number of registers currently busy

Behaviour:
- Reset (reset==0 at rising clk):
  - all registers become 0, all busy bits cleared, busy_count=0.
  - data_out reads 0 and busy_out reads 0 from the following cycle.
  - Writes and allocs in the reset cycle are ignored.
- Write:
  - At rising clk, for each k with write[k]=1 and addr_in[k]!=0, reg[addr_in[k]] <= data_in[k].
  - Result is visible on data_out in the next cycle (1-cycle write latency, no bypass; see Optional Feature).
- Write conflict: several write ports targeting the same address in one cycle -> the highest-index port's data is stored.
- Register 0:
  - Writes to address 0 are dropped; reads of address 0 always return 0.
  - busy[0] is never set.
- Read: data_out[j] = reg[addr_out[j]], purely combinational, independent per port; any number of ports may read the same address.
- Scoreboard:
  - At rising clk, any write[k]=1 with addr_in[k]!=0 clears busy[addr_in[k]].
  - alloc=1 with alloc_addr!=0 sets busy[alloc_addr].
  - Simultaneous alloc and write to the same address -> busy ends SET (the new producer wins).
  - Write to a non-busy register is legal and leaves busy at 0.
  - Alloc of an already-busy register is legal; busy stays 1 and the count is unchanged.
- busy_out[j] = busy[addr_out[j]], combinational.
- busy_count:
  - Registered population count of the busy bits, updated in the same edge as the busy bits.
  - Range 0..(1<<ADDRESS_SIZE)-1; cannot overflow since busy[0] is always 0.

Optional Feature:
Macro REGISTER_BANK_MP_BYPASS_EN.
- Defined: write-through forwarding on the read path.
  - If write[k]=1, addr_in[k]==addr_out[j] and the address is !=0, then data_out[j]=data_in[k] in the same cycle.
  - The highest-index matching port wins.
  - busy_out[j] is forced to 0 for that port in that cycle, unless alloc targets the same address in the same cycle, in which case it stays 1.
- Not defined: reads return only the stored value; the new data appears the cycle after the write, and busy_out shows 1 until the clearing edge.
- Address-0 behaviour is identical in both builds.

Test Plan:
1. Reset=0 for 2 cycles with write=2'b11 to addr 3 and 4 -> after release, reading 3 and 4 gives 0; busy_count=0.
2. write[0]=1 with addr 5, data 0xDEADBEEF -> next cycle, data_out[0] (addr 5) = 0xDEADBEEF. With BYPASS_EN, also equals 0xDEADBEEF in the write cycle; without it, the old value 0.
3. Both ports write addr 7, data 0x11 on port 0 and 0x22 on port 1 -> reg7 = 0x22; write 0xFF to addr 0 -> reads of addr 0 stay 0.
4. Alloc addr 9 -> next cycle busy_out=1 and busy_count=1; then write addr 9 -> busy clears and busy_count=0.
5. Alloc 9 and write 9 in the same cycle, with 9 already busy -> busy_out stays 1 and busy_count is unchanged.
6. Alloc addrs 1..31 over 31 cycles -> busy_count=31; then alloc addr 0 -> busy_count stays 31 and busy_out for addr 0 is 0. Reset mid-sequence -> busy_count=0 on the next cycle.
